// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package inst_fetch_unit_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'h0800;
  localparam logic [ADDR_W-1:0]  DEF_PC_STEP   = 16'd4;

  // Fetch-side state, kept for observation only; no output depends on it.
  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_HOLD  = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

  // One prefetch queue entry: the fetch address and the word returned for it.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  // Next sequential fetch address; wraps silently modulo 2^16.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc,
                                                   input logic [ADDR_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {pc, instr} entries with a combinational head and a
// clear that empties it in one edge (used on branch redirects).
module inst_fetch_unit_fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  fq_entry_t     i_wr_data,
  output fq_entry_t     o_head,
  output logic [CW-1:0] o_count
);

  fq_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Entry storage; stale contents are never visible because count gates the head.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy is tracked separately so full and
  // empty are unambiguous.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch address, samples the instruction memory
// every cycle it is allowed to, and buffers words in a prefetch queue for decode.
// Memory-conflict cycles are absorbed by the queue rather than stalling decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = DEF_PC_STEP,
  parameter int          FQ_DEPTH  = 4,
  parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemConflict,
  output logic [15:0]               im_pc,
  input  logic [15:0]               im_instruction,
  input  logic                      branch_taken,
  input  logic [15:0]               branch_target,
  input  logic                      id_ready,
  output logic                      if_valid,
  output logic [15:0]               if_instruction,
  output logic [15:0]               if_pc,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FQ_DEPTH);

  logic [15:0]   r_fetch_pc;
  fetch_state_e  r_fetch_state;

  logic          w_not_empty;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count;
  fq_entry_t     w_head;
  fq_entry_t     w_wr_data;

  // A branch discards the head rather than consuming it, so it blocks both
  // push and pop; a full queue may still accept a word when decode frees a slot.
  assign w_not_empty = (w_count != '0);
  assign w_pop       = w_not_empty & id_ready & ~branch_taken;
  assign w_push      = ~branch_taken & ~MemConflict & ((w_count < FULL_COUNT) | w_pop);
  assign w_wr_data   = {r_fetch_pc, im_instruction};

  inst_fetch_unit_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (branch_taken),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (w_wr_data),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  // Fetch address: redirect on branch, advance only when the sampled word was queued,
  // otherwise hold so the same address is refetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      r_fetch_pc <= branch_target;
    end else if (w_push) begin
      r_fetch_pc <= pc_advance(r_fetch_pc, PC_STEP);
    end
  end

  // Fetch state tracker: RUN while pushing, HOLD while gated, FLUSH for the cycle after a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_state <= FS_RUN;
    end else if (branch_taken) begin
      r_fetch_state <= FS_FLUSH;
    end else begin
      case (r_fetch_state)
        FS_RUN:   r_fetch_state <= w_push ? FS_RUN : FS_HOLD;
        FS_HOLD:  r_fetch_state <= w_push ? FS_RUN : FS_HOLD;
        FS_FLUSH: r_fetch_state <= w_push ? FS_RUN : FS_HOLD;
        default:  r_fetch_state <= FS_RUN;
      endcase
    end
  end

  assign im_pc          = r_fetch_pc;
  assign if_valid       = w_not_empty;
  assign if_instruction = w_not_empty ? w_head.instr : NOP_INSTR;
  assign if_pc          = w_not_empty ? w_head.pc : 16'h0000;
  assign fq_count       = w_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the fetch behaviour.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        MemConflict;
  logic [15:0] im_pc;
  logic [15:0] im_instruction;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instruction;
  logic [15:0] if_pc;
  logic [2:0]  fq_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] mem [0:16383];

  // Reference model: what decode should see, as plain queues.
  logic [15:0] m_pc_q[$];
  logic [15:0] m_ins_q[$];
  logic [15:0] m_fpc;
  int          m_state;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .MemConflict    (MemConflict),
    .im_pc          (im_pc),
    .im_instruction (im_instruction),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .fq_count       (fq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = m_pc_q.size();
    chk("if_valid", 32'(if_valid), 32'(n != 0));
    chk("if_pc",    32'(if_pc),    (n != 0) ? 32'(m_pc_q[0])  : 32'h0000);
    chk("if_instr", 32'(if_instruction), (n != 0) ? 32'(m_ins_q[0]) : 32'h0800);
    chk("fq_count", 32'(fq_count), 32'(n));
    chk("im_pc",    32'(im_pc),    32'(m_fpc));
    chk("state",    32'(int'(dut.r_fetch_state)), 32'(m_state));
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare.
  task automatic drive(input logic r, input logic mc, input logic rdy,
                       input logic br, input logic [15:0] tgt);
    bit do_pop;
    bit do_push;
    rst           = r;
    MemConflict   = mc;
    id_ready      = rdy;
    branch_taken  = br;
    branch_target = tgt;
    im_instruction = mc ? 16'($urandom) : mem[im_pc[15:2]];
    if (r) begin
      m_pc_q.delete();
      m_ins_q.delete();
      m_fpc   = 16'h0000;
      m_state = 0;
    end else if (br) begin
      m_pc_q.delete();
      m_ins_q.delete();
      m_fpc   = tgt;
      m_state = 2;
    end else begin
      do_pop  = (m_pc_q.size() != 0) && rdy;
      do_push = !mc && ((m_pc_q.size() < 4) || do_pop);
      if (do_pop) begin
        void'(m_pc_q.pop_front());
        void'(m_ins_q.pop_front());
      end
      if (do_push) begin
        m_pc_q.push_back(m_fpc);
        m_ins_q.push_back(mem[m_fpc[15:2]]);
        m_fpc = m_fpc + 16'd4;
      end
      m_state = do_push ? 0 : 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    $display("cyc %0d rst=%0b mc=%0b rdy=%0b br=%0b -> v=%0b pc=%h ins=%h cnt=%0d im_pc=%h",
             cyc, r, mc, rdy, br, if_valid, if_pc, if_instruction, fq_count, im_pc);
  endtask

  initial begin
    logic        r_r;
    logic        r_mc;
    logic        r_rdy;
    logic        r_br;
    logic [15:0] r_tgt;

    for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
    rst = 1'b1; MemConflict = 1'b0; id_ready = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; im_instruction = 16'h0000;

    // Reset, then streaming with decode always ready
    drive(1, 0, 0, 0, 16'h0);
    repeat (5) drive(0, 0, 1, 0, 16'h0);

    // Decode stalled long enough to fill the queue, then released
    drive(1, 0, 0, 0, 16'h0);
    repeat (6) drive(0, 0, 0, 0, 16'h0);
    chk("t2_im_pc", 32'(im_pc), 32'h0010);
    chk("t2_count", 32'(fq_count), 32'd4);
    repeat (6) drive(0, 0, 1, 0, 16'h0);

    // Queue holding 3, memory conflict while decode drains it
    drive(1, 0, 0, 0, 16'h0);
    repeat (3) drive(0, 0, 0, 0, 16'h0);
    repeat (3) drive(0, 1, 1, 0, 16'h0);
    chk("t3_bubble", 32'(if_valid), 32'd0);
    chk("t3_im_pc", 32'(im_pc), 32'h000C);
    repeat (3) drive(0, 0, 1, 0, 16'h0);

    // Branch while full
    drive(1, 0, 0, 0, 16'h0);
    repeat (4) drive(0, 0, 0, 0, 16'h0);
    drive(0, 0, 0, 1, 16'h0040);
    chk("t4_valid", 32'(if_valid), 32'd0);
    chk("t4_count", 32'(fq_count), 32'd0);
    chk("t4_im_pc", 32'(im_pc), 32'h0040);
    drive(0, 0, 1, 0, 16'h0);
    chk("t4_if_pc", 32'(if_pc), 32'h0040);

    // Priority: branch over conflict, reset over branch
    drive(0, 1, 1, 1, 16'h1234);
    chk("t5_br_mc", 32'(im_pc), 32'h1234);
    drive(1, 0, 1, 1, 16'h5678);
    chk("t5_rst_br", 32'(im_pc), 32'h0000);

    // Address wrap at the top of the space
    drive(0, 0, 0, 1, 16'hFFF8);
    repeat (3) drive(0, 0, 0, 0, 16'h0);
    chk("t6_pc0", 32'(if_pc), 32'hFFF8);
    drive(0, 0, 1, 0, 16'h0);
    chk("t6_pc1", 32'(if_pc), 32'hFFFC);
    drive(0, 0, 1, 0, 16'h0);
    chk("t6_pc2", 32'(if_pc), 32'h0000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_r   = ($urandom_range(0, 99) < 1);
      r_mc  = ($urandom_range(0, 99) < 25);
      r_rdy = ($urandom_range(0, 99) < 70);
      r_br  = ($urandom_range(0, 99) < 5);
      r_tgt = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                          : 16'($urandom);
      drive(r_r, r_mc, r_rdy, r_br, r_tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
